// File: rtl/fp_seq_div_pkg.sv
// fpu_pkg: shared FPU types, IEEE-754 single constants and exception flag bit positions.
package fpu_pkg;
    typedef enum logic [2:0] {IDLE, PREP, ITER, ROUND, DONE} state_e;
    localparam logic [31:0] FP_CANON_NAN = 32'h7FC00000;
    localparam logic [31:0] FP_POS_INF   = 32'h7F800000;
    localparam int NV = 4;
    localparam int DZ = 3;
    localparam int OF = 2;
    localparam int UF = 1;
    localparam int NX = 0;
    localparam int EXP_W  = 8;
    localparam int FRAC_W = 23;
endpackage

// File: rtl/fp_seq_div_if.sv
// fp_seq_div_if: operand/result valid-ready handshake bundle for the sequential divider.
interface fp_seq_div_if;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] op1;
    logic [31:0] op2;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] result;
    logic [4:0]  fflags;
    modport master(output in_valid, op1, op2, out_ready, input in_ready, out_valid, result, fflags);
    modport slave(input in_valid, op1, op2, out_ready, output in_ready, out_valid, result, fflags);
endinterface

// File: rtl/fp_seq_div_classify.sv
// fp_classify: combinational IEEE-754 single classification; subnormals report as zero.
module fp_classify
    import fpu_pkg::*;
(
    input  logic [31:0] i_x,
    output logic        o_sign,
    output logic        o_zero,
    output logic        o_inf,
    output logic        o_nan,
    output logic        o_snan
);
    logic [EXP_W-1:0]  w_exp;
    logic [FRAC_W-1:0] w_frac;
    assign w_exp  = i_x[FRAC_W +: EXP_W];
    assign w_frac = i_x[FRAC_W-1:0];
    assign o_sign = i_x[31];
    assign o_zero = w_exp == '0;
    assign o_inf  = (&w_exp) && w_frac == '0;
    assign o_nan  = (&w_exp) && w_frac != '0;
    assign o_snan = o_nan && !w_frac[FRAC_W-1];
endmodule

// File: rtl/fp_seq_div.sv
// fp_seq_div: multi-cycle IEEE-754 single divider, one restoring step per clock, RNE rounding.
module fp_seq_div
    import fpu_pkg::*;
(
    input  logic         clk,
    input  logic         rst_n,
    fp_seq_div_if.slave  bus
);
    localparam logic [2:0] S_IDLE  = IDLE;
    localparam logic [2:0] S_PREP  = PREP;
    localparam logic [2:0] S_ITER  = ITER;
    localparam logic [2:0] S_ROUND = ROUND;
    localparam logic [2:0] S_DONE  = DONE;

    logic [2:0]  r_state;
    logic [31:0] r_a, r_b, r_result;
    logic [25:0] r_rem;
    logic [24:0] r_q;
    logic [9:0]  r_exp;
    logic [4:0]  r_cnt, r_fflags;

    logic w_as, w_az, w_ai, w_an, w_asn, w_bs, w_bz, w_bi, w_bn, w_bsn;
    fp_classify u_cls_a (.i_x(r_a), .o_sign(w_as), .o_zero(w_az), .o_inf(w_ai), .o_nan(w_an), .o_snan(w_asn));
    fp_classify u_cls_b (.i_x(r_b), .o_sign(w_bs), .o_zero(w_bz), .o_inf(w_bi), .o_nan(w_bn), .o_snan(w_bsn));

    logic        w_sign, w_special, w_sp_nan, w_sp_inf, w_lt, w_ge, w_gs, w_up, w_of, w_uf;
    logic [23:0] w_ma, w_mb, w_sum;
    logic [25:0] w_diff;
    logic [9:0]  w_exp0, w_exp_r;
    logic [31:0] w_sp_res, w_rd_res;
    logic [4:0]  w_sp_flg, w_rd_flg;

    assign w_sign    = w_as ^ w_bs;
    assign w_special = w_az | w_ai | w_an | w_bz | w_bi | w_bn;
    assign w_sp_nan  = w_an | w_bn | (w_az & w_bz) | (w_ai & w_bi);
    assign w_sp_inf  = !w_sp_nan && (w_bz || w_ai);
    assign w_sp_res  = w_sp_nan ? FP_CANON_NAN : w_sp_inf ? (FP_POS_INF | {w_sign, 31'd0}) : {w_sign, 31'd0};

    assign w_ma   = {1'b1, r_a[22:0]};
    assign w_mb   = {1'b1, r_b[22:0]};
    assign w_lt   = w_ma < w_mb;
    assign w_exp0 = {2'b0, r_a[30:23]} - {2'b0, r_b[30:23]} + (w_lt ? 10'd126 : 10'd127);
    assign w_ge   = r_rem >= {2'b0, w_mb};
    assign w_diff = r_rem - {2'b0, w_mb};

    // The leading quotient bit has shifted out of r_q, leaving frac/guard/sticky in place.
    assign w_gs     = r_q[1] | r_q[0] | (r_rem != '0);
    assign w_up     = r_q[1] & (r_q[0] | (r_rem != '0) | r_q[2]);
    assign w_sum    = {1'b0, r_q[24:2]} + {23'd0, w_up};
    assign w_exp_r  = r_exp + {9'd0, w_sum[23]};
    assign w_of     = $signed(w_exp_r) >= 10'sd255;
    assign w_uf     = $signed(w_exp_r) <= 10'sd0;
    assign w_rd_res = w_of ? (FP_POS_INF | {w_sign, 31'd0}) : w_uf ? {w_sign, 31'd0} : {w_sign, w_exp_r[7:0], w_sum[22:0]};

    always_comb begin
        w_sp_flg     = '0;
        w_sp_flg[NV] = (w_an | w_bn) ? (w_asn | w_bsn) : w_sp_nan;
        w_sp_flg[DZ] = !w_sp_nan && w_bz && !w_ai;
        w_rd_flg     = '0;
        w_rd_flg[OF] = w_of;
        w_rd_flg[UF] = w_uf && !w_of;
        w_rd_flg[NX] = w_of | w_uf | w_gs;
    end

    assign bus.in_ready  = r_state == S_IDLE;
    assign bus.out_valid = r_state == S_DONE;
    assign bus.result    = r_result;
    assign bus.fflags    = r_fflags;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= S_IDLE;
            r_a      <= '0;
            r_b      <= '0;
            r_result <= '0;
            r_fflags <= '0;
            r_rem    <= '0;
            r_q      <= '0;
            r_exp    <= '0;
            r_cnt    <= '0;
        end else begin
            case (r_state)
                S_IDLE: if (bus.in_valid) begin
                    r_a     <= bus.op1;
                    r_b     <= bus.op2;
                    r_state <= S_PREP;
                end
                S_PREP: if (w_special) begin
                    r_result <= w_sp_res;
                    r_fflags <= w_sp_flg;
                    r_state  <= S_DONE;
                end else begin
                    r_rem   <= w_lt ? {1'b0, w_ma, 1'b0} : {2'b0, w_ma};
                    r_exp   <= w_exp0;
                    r_q     <= '0;
                    r_cnt   <= '0;
                    r_state <= S_ITER;
                end
                S_ITER: begin
                    r_q     <= {r_q[23:0], w_ge};
                    r_rem   <= (w_ge ? w_diff : r_rem) << 1;
                    r_cnt   <= r_cnt + 5'd1;
                    r_state <= (r_cnt == 5'd25) ? S_ROUND : S_ITER;
                end
                S_ROUND: begin
                    r_result <= w_rd_res;
                    r_fflags <= w_rd_flg;
                    r_state  <= S_DONE;
                end
                S_DONE: if (bus.out_ready) r_state <= S_IDLE;
                default: r_state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_fp_seq_div.sv
// tb_fp_seq_div: randomized handshake bench for fp_seq_div against an exact-division reference model.
module tb_fp_seq_div;
    typedef struct {logic [31:0] r; logic [4:0] f; int lat;} exp_t;
    typedef struct {exp_t e; int acc; bit seen;} txn_t;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    int checks = 0, failures = 0, cyc = 0, ordy_mode = 1;
    bit prev_pop = 1'b0;
    txn_t q[$];

    fp_seq_div_if bus();
    fp_seq_div dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, req, $time);
        end
    endtask

    // Quotient from exact integer division of the scaled significands, then RNE on that.
    function automatic exp_t model(input logic [31:0] a, input logic [31:0] b);
        exp_t e;
        logic s, az, bz, ai, bi, an, bn, g, st;
        logic [7:0] ea, eb;
        logic [63:0] num, mb, qf, rm, mant;
        int ex, sh;
        s = a[31] ^ b[31];
        ea = a[30:23];
        eb = b[30:23];
        az = ea == 8'd0;
        bz = eb == 8'd0;
        ai = ea == 8'hFF && a[22:0] == 23'd0;
        bi = eb == 8'hFF && b[22:0] == 23'd0;
        an = ea == 8'hFF && a[22:0] != 23'd0;
        bn = eb == 8'hFF && b[22:0] != 23'd0;
        e.lat = 1;
        e.f = 5'd0;
        e.r = {s, 31'd0};
        if (an || bn) begin
            e.r = 32'h7FC00000;
            e.f[4] = (an && !a[22]) || (bn && !b[22]);
        end else if ((az && bz) || (ai && bi)) begin
            e.r = 32'h7FC00000;
            e.f = 5'b10000;
        end else if (bz && !ai) begin
            e.r = {s, 31'h7F800000};
            e.f = 5'b01000;
        end else if (ai) begin
            e.r = {s, 31'h7F800000};
        end else if (!(az || bi)) begin
            e.lat = 28;
            num = {1'b1, a[22:0], 40'd0};
            mb = {40'd0, 1'b1, b[22:0]};
            qf = num / mb;
            rm = num % mb;
            if (qf[40]) begin ex = int'(ea) - int'(eb) + 127; sh = 17; end
            else begin ex = int'(ea) - int'(eb) + 126; sh = 16; end
            mant = qf >> sh;
            g = qf[sh-1];
            st = ((qf & ((64'd1 << (sh - 1)) - 64'd1)) != 64'd0) || rm != 64'd0;
            if (g && (st || mant[0])) mant = mant + 64'd1;
            if (mant[24]) begin mant = mant >> 1; ex++; end
            if (ex >= 255) begin e.r = {s, 31'h7F800000}; e.f = 5'b00101; end
            else if (ex <= 0) begin e.r = {s, 31'd0}; e.f = 5'b00011; end
            else begin e.r = {s, 8'(ex), mant[22:0]}; e.f = {4'd0, g | st}; end
        end
        return e;
    endfunction

    function automatic logic [31:0] rnd_fp();
        logic [31:0] sp [8];
        logic [22:0] fr;
        int k;
        sp = '{32'h00000000, 32'h80000000, 32'h7F800000, 32'hFF800000,
               32'h7FC00000, 32'h7F800001, 32'h7FA00000, 32'h00400000};
        k = $urandom_range(0, 9);
        fr = ($urandom_range(0, 3) == 0) ? 23'd0 : 23'($urandom);
        if (k == 0) return sp[$urandom_range(0, 7)];
        if (k == 1) return {1'($urandom_range(0, 1)), 8'($urandom_range(240, 254)), fr};
        if (k == 2) return {1'($urandom_range(0, 1)), 8'($urandom_range(1, 12)), fr};
        if (k == 3) return 32'($urandom);
        return {1'($urandom_range(0, 1)), 8'($urandom_range(100, 154)), fr};
    endfunction

    task automatic run_op(input logic [31:0] a, input logic [31:0] b);
        txn_t t;
        bus.op1 = a;
        bus.op2 = b;
        bus.in_valid = 1'b1;
        for (int i = 0; i < 200 && !bus.in_ready; i++) @(negedge clk);
        if (!bus.in_ready) begin
            chk("accept_timeout", {31'd0, bus.in_ready}, 32'd1);
            bus.in_valid = 1'b0;
            return;
        end
        @(posedge clk);
        #1;
        t.e = model(a, b);
        t.acc = cyc;
        t.seen = 1'b0;
        q.push_back(t);
        bus.in_valid = 1'b0;
        @(negedge clk);
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 400 && (q.size() != 0 || !bus.in_ready); i++) @(negedge clk);
        chk("drain", q.size(), 32'd0);
    endtask

    initial begin
        bus.out_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            bus.out_ready = (ordy_mode == 0) ? 1'b0 : (ordy_mode == 1) ? 1'b1 : ($urandom_range(0, 3) != 0);
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (rst_n) begin
                if (prev_pop) begin
                    chk("idle_after_pop", {31'd0, bus.in_ready}, 32'd1);
                    chk("valid_drop", {31'd0, bus.out_valid}, 32'd0);
                end
                prev_pop = 1'b0;
                if (bus.out_valid) begin
                    if (q.size() == 0) chk("unexpected_valid", {31'd0, bus.out_valid}, 32'd0);
                    else begin
                        chk("result", bus.result, q[0].e.r);
                        chk("fflags", {27'd0, bus.fflags}, {27'd0, q[0].e.f});
                        chk("in_ready_done", {31'd0, bus.in_ready}, 32'd0);
                        if (!q[0].seen) begin
                            chk("latency", cyc - q[0].acc, q[0].e.lat);
                            q[0].seen = 1'b1;
                        end
                        if (bus.out_ready) begin
                            void'(q.pop_front());
                            prev_pop = 1'b1;
                        end
                    end
                end
            end
        end
    end

    initial begin
        exp_t m;
        bus.in_valid = 1'b0;
        bus.op1 = '0;
        bus.op2 = '0;
        #2 rst_n = 1'b0;
        #1;
        chk("rst_in_ready", {31'd0, bus.in_ready}, 32'd1);
        chk("rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
        chk("rst_result", bus.result, 32'd0);
        chk("rst_fflags", {27'd0, bus.fflags}, 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        m = model(32'h40C00000, 32'h40000000);
        chk("pin_6_2", m.r, 32'h40400000); chk("pin_6_2_f", {27'd0, m.f}, 32'h0); chk("pin_6_2_lat", m.lat, 28);
        m = model(32'h3F800000, 32'h40400000);
        chk("pin_1_3", m.r, 32'h3EAAAAAB); chk("pin_1_3_f", {27'd0, m.f}, 32'h1);
        m = model(32'h3F800000, 32'h00000000);
        chk("pin_dz", m.r, 32'h7F800000); chk("pin_dz_f", {27'd0, m.f}, 32'h08); chk("pin_dz_lat", m.lat, 1);
        m = model(32'h00000000, 32'h00000000);
        chk("pin_00", m.r, 32'h7FC00000); chk("pin_00_f", {27'd0, m.f}, 32'h10);
        m = model(32'h7F800001, 32'h3F800000);
        chk("pin_snan", m.r, 32'h7FC00000); chk("pin_snan_f", {27'd0, m.f}, 32'h10);
        m = model(32'h7F000000, 32'h3E800000);
        chk("pin_of", m.r, 32'h7F800000); chk("pin_of_f", {27'd0, m.f}, 32'h05);
        m = model(32'h00800000, 32'h40000000);
        chk("pin_uf", m.r, 32'h00000000); chk("pin_uf_f", {27'd0, m.f}, 32'h03);

        run_op(32'h40C00000, 32'h40000000); wait_idle();
        run_op(32'h3F800000, 32'h40400000); wait_idle();
        run_op(32'h3F800000, 32'h00000000); wait_idle();
        run_op(32'h00000000, 32'h00000000); wait_idle();
        run_op(32'h7F800001, 32'h3F800000); wait_idle();
        run_op(32'h7F000000, 32'h3E800000); wait_idle();
        run_op(32'h00800000, 32'h40000000); wait_idle();

        ordy_mode = 0;
        run_op(32'hC0C00000, 32'h40000000);
        for (int i = 0; i < 100 && !bus.out_valid; i++) @(negedge clk);
        repeat (10) @(negedge clk);
        chk("hold_valid", {31'd0, bus.out_valid}, 32'd1);
        chk("hold_result", bus.result, 32'hC0400000);
        ordy_mode = 1;
        wait_idle();

        run_op(32'h3F800000, 32'h40400000);
        repeat (9) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("midrst_in_ready", {31'd0, bus.in_ready}, 32'd1);
        chk("midrst_out_valid", {31'd0, bus.out_valid}, 32'd0);
        chk("midrst_result", bus.result, 32'd0);
        q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        repeat (40) @(negedge clk);
        run_op(32'h40C00000, 32'h40000000); wait_idle();

        ordy_mode = 2;
        repeat (160) run_op(rnd_fp(), rnd_fp());
        ordy_mode = 1;
        wait_idle();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
